// File: rtl/pc_sequencer.sv
// Program counter and run-control stage: sequences IDLE/RUN/DONE for three stored
// programs, advances the fetch address and counts the cycles spent in RUN.
module pc_sequencer #(
    parameter int PC_W       = 10,
    parameter int CNT_W      = 16,
    parameter int PROG1_BASE = 0,
    parameter int PROG2_BASE = 256,
    parameter int PROG3_BASE = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  abs_target,
    input  logic             stall,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PC_W-1:0]  pc_d;
    logic [CNT_W-1:0] cnt_d;
    logic [PC_W-1:0]  base;
    logic             launch;

    always_comb begin
        base = PC_W'(PROG1_BASE);
        case (prog_sel)
            2'd0:    base = PC_W'(PROG1_BASE);
            2'd1:    base = PC_W'(PROG2_BASE);
            2'd2:    base = PC_W'(PROG3_BASE);
            default: base = PC_W'(PROG1_BASE);
        endcase
    end

    // prog_sel == 3 is reserved; a start with it is dropped entirely
    assign launch = start && (prog_sel != 2'd3);

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        cnt_d   = cycle_count;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = RUN;
                    pc_d    = base;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cycle_count != {CNT_W{1'b1}}) begin
                    cnt_d = cycle_count + CNT_W'(1);
                end
                if (halt) begin
                    state_d = DONE;
                end else if (stall) begin
                    pc_d = pc;
                end else if (branch_taken) begin
                    pc_d = abs_target;
                end else begin
                    pc_d = pc + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            cycle_count <= cnt_d;
        end
    end

    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
